// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the scaled VGA controller: default 640x480@60 timing
// constants, the output mode encoding and a helper that derives a line/frame
// total from its four timing segments.
// -----------------------------------------------------------------------------
package vga_pkg;

    // Default horizontal timing, in pixel clocks
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;

    // Default vertical timing, in lines
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    typedef enum logic [1:0] {
        MODE_FB      = 2'd0,  // framebuffer pass-through
        MODE_BARS    = 2'd1,  // eight vertical colour bars
        MODE_CHECKER = 2'd2,  // 32x32 checkerboard
        MODE_WHITE   = 2'd3   // solid white
    } mode_e;

    // Total period of one axis (active + front porch + sync + back porch)
    function automatic int vga_total(input int active, input int fp,
                                     input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Free-running horizontal/vertical counters and the raw (undelayed,
// active-high) sync and active-region flags derived from them.
//
// Ports
//   clk       in   pixel clock
//   reset     in   synchronous active-high reset (counters to 0,0)
//   h_cnt     out  horizontal position, 0..H_TOTAL-1
//   v_cnt     out  vertical position,   0..V_TOTAL-1
//   h_last    out  h_cnt is on the last clock of the line
//   v_last    out  v_cnt is on the last line of the frame
//   active    out  (h_cnt, v_cnt) lies in the visible region
//   hsync_on  out  horizontal sync interval (active-high, before polarity)
//   vsync_on  out  vertical sync interval   (active-high, before polarity)
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int H_CNT_W  = $clog2(vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
    parameter int V_CNT_W  = $clog2(vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
    input  logic               clk,
    input  logic               reset,
    output logic [H_CNT_W-1:0] h_cnt,
    output logic [V_CNT_W-1:0] v_cnt,
    output logic               h_last,
    output logic               v_last,
    output logic               active,
    output logic               hsync_on,
    output logic               vsync_on
);

    localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [H_CNT_W-1:0] H_MAX  = H_CNT_W'(H_TOTAL - 1);
    localparam logic [H_CNT_W-1:0] H_ACT  = H_CNT_W'(H_ACTIVE);
    localparam logic [H_CNT_W-1:0] HS_BEG = H_CNT_W'(H_ACTIVE + H_FP);
    localparam logic [H_CNT_W-1:0] HS_END = H_CNT_W'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [V_CNT_W-1:0] V_MAX  = V_CNT_W'(V_TOTAL - 1);
    localparam logic [V_CNT_W-1:0] V_ACT  = V_CNT_W'(V_ACTIVE);
    localparam logic [V_CNT_W-1:0] VS_BEG = V_CNT_W'(V_ACTIVE + V_FP);
    localparam logic [V_CNT_W-1:0] VS_END = V_CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    assign h_last = (h_cnt == H_MAX);
    assign v_last = (v_cnt == V_MAX);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + V_CNT_W'(1);
        end else begin
            h_cnt <= h_cnt + H_CNT_W'(1);
        end
    end

    assign active   = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hsync_on = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign vsync_on = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

endmodule

// File: rtl/vga_scaled_controller.sv
// -----------------------------------------------------------------------------
// vga_scaled_controller
// VGA controller that upscales a small framebuffer by 2^SCALE_SHIFT in both
// axes, or replaces it with one of three built-in test patterns.
//
// Pipeline: counters and addr at cycle t, framebuffer data (din) at t+1,
// registered R/G/B at t+2. Syncs and frame_start are delayed to match.
//
// Ports
//   clk          in   pixel clock
//   reset        in   synchronous active-high reset
//   mode         in   0 framebuffer, 1 colour bars, 2 checkerboard, 3 white;
//                     sampled once per frame at h_cnt=0, v_cnt=0
//   din          in   framebuffer read data, valid one clock after addr
//   addr         out  framebuffer read address
//   hsync/vsync  out  syncs, asserted level set by SYNC_POL
//   R/G/B        out  pixel colour, 0 outside the visible region
//   frame_start  out  one-cycle pulse with the first visible pixel of a frame
// -----------------------------------------------------------------------------
module vga_scaled_controller
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = VGA_H_ACTIVE,
    parameter int H_FP        = VGA_H_FP,
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int H_BP        = VGA_H_BP,
    parameter int V_ACTIVE    = VGA_V_ACTIVE,
    parameter int V_FP        = VGA_V_FP,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int V_BP        = VGA_V_BP,
    parameter int COLOR_W     = 2,
    parameter int SCALE_SHIFT = 1,
    parameter int ADDR_W      = 17,
    parameter int SYNC_POL    = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         mode,
    input  logic [COLOR_W-1:0] din,
    output logic [ADDR_W-1:0]  addr,
    output logic               hsync,
    output logic               vsync,
    output logic [COLOR_W-1:0] R,
    output logic [COLOR_W-1:0] G,
    output logic [COLOR_W-1:0] B,
    output logic               frame_start
);

    localparam int H_CNT_W = $clog2(vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
    localparam int V_CNT_W = $clog2(vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP));

    localparam logic [H_CNT_W-1:0] H_ACT    = H_CNT_W'(H_ACTIVE);
    localparam logic [V_CNT_W-1:0] V_ACT    = V_CNT_W'(V_ACTIVE);
    localparam logic [H_CNT_W-1:0] COL_MASK = H_CNT_W'((1 << SCALE_SHIFT) - 1);
    localparam logic [V_CNT_W-1:0] ROW_MASK = V_CNT_W'((1 << SCALE_SHIFT) - 1);
    localparam logic [ADDR_W-1:0]  FB_W     = ADDR_W'(H_ACTIVE >> SCALE_SHIFT);

    localparam logic SYNC_ON   = (SYNC_POL != 0);
    localparam logic SYNC_IDLE = ~SYNC_ON;

    localparam logic [COLOR_W-1:0] ONES = {COLOR_W{1'b1}};

    // ---------------------------------------------------------------- timing
    logic [H_CNT_W-1:0] h_cnt;
    logic [V_CNT_W-1:0] v_cnt;
    logic               h_last;
    logic               v_last;
    logic               active;
    logic               hsync_on;
    logic               vsync_on;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .H_CNT_W  (H_CNT_W),
        .V_CNT_W  (V_CNT_W)
    ) u_timing (
        .clk      (clk),
        .reset    (reset),
        .h_cnt    (h_cnt),
        .v_cnt    (v_cnt),
        .h_last   (h_last),
        .v_last   (v_last),
        .active   (active),
        .hsync_on (hsync_on),
        .vsync_on (vsync_on)
    );

    // ------------------------------------------------------ address generator
    // addr is registered alongside the counters, so each update computes the
    // address of the pixel the counters move to on the same edge.
    logic [V_CNT_W-1:0] v_next;
    logic [H_CNT_W-1:0] h_next;
    logic [ADDR_W-1:0]  line_start;

    assign v_next = v_last ? '0 : v_cnt + V_CNT_W'(1);
    assign h_next = h_cnt + H_CNT_W'(1);  // only used when h_last is low

    always_ff @(posedge clk) begin
        if (reset) begin
            addr       <= '0;
            line_start <= '0;
        end else if (h_last) begin
            if ((v_next >= V_ACT) || (v_next == '0)) begin
                // Entering vertical blanking or a new frame: park at 0
                line_start <= '0;
                addr       <= '0;
            end else if ((v_next & ROW_MASK) == '0) begin
                line_start <= line_start + FB_W;
                addr       <= line_start + FB_W;
            end else begin
                // Same framebuffer row repeated: rewind
                addr <= line_start;
            end
        end else if (active && ((h_next & COL_MASK) == '0) && (h_next < H_ACT)) begin
            // Step once per 2^SCALE_SHIFT pixels; the last step of the line is
            // suppressed so addr holds through horizontal blanking.
            addr <= addr + ADDR_W'(1);
        end
    end

    // ------------------------------------------------------- pattern (cycle t)
    // The frame's mode is taken directly from the input at (0,0) so the first
    // pixel already uses it, then held in mode_q for the rest of the frame.
    mode_e              mode_q;
    mode_e              cur_mode;
    logic [2:0]         bar;
    logic [COLOR_W-1:0] pat_r;
    logic [COLOR_W-1:0] pat_g;
    logic [COLOR_W-1:0] pat_b;

    assign cur_mode = ((h_cnt == '0) && (v_cnt == '0)) ? mode_e'(mode) : mode_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= MODE_FB;
        end else begin
            mode_q <= cur_mode;
        end
    end

    // Bar index h*8/H_ACTIVE by threshold compares: h reaches bar k at
    // ceil(k*H_ACTIVE/8).
    always_comb begin
        bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (h_cnt >= H_CNT_W'((k * H_ACTIVE + 7) / 8)) begin
                bar = 3'(k);
            end
        end
    end

    // NOTE: every combinational output gets a default first so no path through
    // the block leaves it unassigned and infers a latch.
    always_comb begin
        pat_r = '0;
        pat_g = '0;
        pat_b = '0;
        unique case (cur_mode)
            MODE_BARS: begin
                pat_r = {COLOR_W{bar[2]}};
                pat_g = {COLOR_W{bar[1]}};
                pat_b = {COLOR_W{bar[0]}};
            end
            MODE_CHECKER: begin
                if (h_cnt[5] ^ v_cnt[5]) begin
                    pat_r = ONES;
                    pat_g = ONES;
                    pat_b = ONES;
                end
            end
            MODE_WHITE: begin
                pat_r = ONES;
                pat_g = ONES;
                pat_b = ONES;
            end
            default: ;  // framebuffer colour is chosen at stage 2 from din
        endcase
    end

    // ---------------------------------------------------- stage 1 (cycle t+1)
    logic               use_fb_d1;
    logic               active_d1;
    logic               hs_d1;
    logic               vs_d1;
    logic               fs_d1;
    logic [COLOR_W-1:0] pat_r_d1;
    logic [COLOR_W-1:0] pat_g_d1;
    logic [COLOR_W-1:0] pat_b_d1;

    // NOTE: the pipeline registers are reset as well, so the flags and colours
    // of an aborted frame cannot leak out after reset is released.
    always_ff @(posedge clk) begin
        if (reset) begin
            use_fb_d1 <= 1'b0;
            active_d1 <= 1'b0;
            hs_d1     <= 1'b0;
            vs_d1     <= 1'b0;
            fs_d1     <= 1'b0;
            pat_r_d1  <= '0;
            pat_g_d1  <= '0;
            pat_b_d1  <= '0;
        end else begin
            use_fb_d1 <= (cur_mode == MODE_FB);
            active_d1 <= active;
            hs_d1     <= hsync_on;
            vs_d1     <= vsync_on;
            fs_d1     <= (h_cnt == '0) && (v_cnt == '0);
            pat_r_d1  <= pat_r;
            pat_g_d1  <= pat_g;
            pat_b_d1  <= pat_b;
        end
    end

    // ---------------------------------------------------- stage 2 (cycle t+2)
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync       <= SYNC_IDLE;
            vsync       <= SYNC_IDLE;
            frame_start <= 1'b0;
            R           <= '0;
            G           <= '0;
            B           <= '0;
        end else begin
            hsync       <= hs_d1 ? SYNC_ON : SYNC_IDLE;
            vsync       <= vs_d1 ? SYNC_ON : SYNC_IDLE;
            frame_start <= fs_d1;
            if (!active_d1) begin
                R <= '0;
                G <= '0;
                B <= '0;
            end else if (use_fb_d1) begin
                R <= din;
                G <= din;
                B <= din;
            end else begin
                R <= pat_r_d1;
                G <= pat_g_d1;
                B <= pat_b_d1;
            end
        end
    end

endmodule

// File: tb/tb_vga_scaled_controller.sv
// -----------------------------------------------------------------------------
// tb_vga_scaled_controller
// Directed bench for vga_scaled_controller. Main instance uses a reduced
// timing (80 clk x 55 lines, 64x48 visible, 2x scale -> 32x24 framebuffer,
// addresses 0..767) so whole frames fit in a short run. A second instance
// with no scaling (32x24 visible, 48 x 31 total) covers the linear address
// walk. Framebuffer model: din = addr[1:0], one clock after addr.
//
// Timeline: cur counts falling edges since reset release; at falling edge
// cur = k the counters/addr describe pixel k, and R/G/B/syncs/frame_start
// show pixel k-2. Pixel (h,v) of frame f is k = f*4400 + v*80 + h.
// -----------------------------------------------------------------------------
module tb_vga_scaled_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mode;

    logic [1:0]  din1;
    logic [16:0] addr1;
    logic        hsync1, vsync1, fs1;
    logic [1:0]  r1, g1, b1;

    logic [1:0]  din2;
    logic [16:0] addr2;
    logic        hsync2, vsync2, fs2;
    logic [1:0]  r2, g2, b2;

    int compared   = 0;
    int mismatched = 0;
    int cur        = 0;
    int max_addr   = 0;

    always #5 clk = ~clk;

    vga_scaled_controller #(
        .H_ACTIVE (64), .H_FP (4), .H_SYNC (8), .H_BP (4),
        .V_ACTIVE (48), .V_FP (2), .V_SYNC (2), .V_BP (3),
        .COLOR_W (2), .SCALE_SHIFT (1), .ADDR_W (17), .SYNC_POL (0)
    ) dut (
        .clk (clk), .reset (reset), .mode (mode), .din (din1), .addr (addr1),
        .hsync (hsync1), .vsync (vsync1), .R (r1), .G (g1), .B (b1),
        .frame_start (fs1)
    );

    vga_scaled_controller #(
        .H_ACTIVE (32), .H_FP (4), .H_SYNC (8), .H_BP (4),
        .V_ACTIVE (24), .V_FP (2), .V_SYNC (2), .V_BP (3),
        .COLOR_W (2), .SCALE_SHIFT (0), .ADDR_W (17), .SYNC_POL (0)
    ) dut_lin (
        .clk (clk), .reset (reset), .mode (mode), .din (din2), .addr (addr2),
        .hsync (hsync2), .vsync (vsync2), .R (r2), .G (g2), .B (b2),
        .frame_start (fs2)
    );

    // Synchronous-read framebuffer models
    always @(posedge clk) begin
        din1 <= addr1[1:0];
        din2 <= addr2[1:0];
    end

    always @(negedge clk) begin
        if (int'(addr1) > max_addr) max_addr = int'(addr1);
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic go(input int k);
        while (cur < k) begin
            @(negedge clk);
            cur++;
        end
    endtask

    task automatic check_rgb(input string tag, input logic [1:0] er,
                             input logic [1:0] eg, input logic [1:0] eb);
        check({tag, ".R"}, 32'(r1), 32'(er));
        check({tag, ".G"}, 32'(g1), 32'(eg));
        check({tag, ".B"}, 32'(b1), 32'(eb));
    endtask

    initial begin
        int exp2;
        int hs_low, vs_low, fs_cnt;

        // ------------------------------------------------------------ reset
        reset = 1'b1;
        mode  = 2'd0;
        repeat (3) @(negedge clk);
        check("rst.addr",  32'(addr1), 32'd0);
        check("rst.hsync", 32'(hsync1), 32'd1);
        check("rst.vsync", 32'(vsync1), 32'd1);
        check("rst.fs",    32'(fs1),    32'd0);
        check_rgb("rst", 2'd0, 2'd0, 2'd0);
        reset = 1'b0;
        cur   = 0;

        // ----------------------------- frame 0, mode 0; unscaled linear walk
        exp2 = 0;
        for (int n = 0; n < 1488; n++) begin
            go(n);
            if ((n % 48) < 32 && (n / 48) < 24) begin
                check("lin.addr", 32'(addr2), 32'(exp2));
                exp2++;
            end
        end
        check("lin.count", 32'(exp2), 32'd768);

        hs_low = 0;
        for (int n = 1600; n < 1680; n++) begin
            go(n);
            if (hsync1 == 1'b0) hs_low++;
        end
        check("hsync.width", 32'(hs_low), 32'd8);

        go(1749); check("hsync.pre_edge",  32'(hsync1), 32'd1);  // pixel (67,21)
        go(1750); check("hsync.post_edge", 32'(hsync1), 32'd0);  // pixel (68,21)
        check("addr.hblank_hold", 32'(addr1), 32'd351);          // pixel (70,21)

        go(3823); check("addr.last", 32'(addr1), 32'd767);       // pixel (63,47)
        go(3825); check_rgb("fb.last", 2'd3, 2'd3, 2'd3);
        go(4010); check("addr.vblank", 32'(addr1), 32'd0);       // pixel (10,50)
        go(4012); check_rgb("fb.vblank", 2'd0, 2'd0, 2'd0);

        // -------------------------------------------- frame 1, still mode 0
        go(4483); check("addr.p3_1", 32'(addr1), 32'd1);         // pixel (3,1)
        go(4485); check_rgb("fb.p3_1", 2'd1, 2'd1, 2'd1);
        go(6000); mode = 2'd1;                                   // at v=20
        go(6812); check_rgb("fb.after_switch", 2'd1, 2'd1, 2'd1); // (10,30) addr 485

        // -------------------------------------------------- frame 2, bars
        go(8801); check("fs.before", 32'(fs1), 32'd0);
        go(8802); check("fs.pulse",  32'(fs1), 32'd1);
        go(8810); check_rgb("bars.h8",  2'd0, 2'd0, 2'd3);       // bar 1
        go(9242); check_rgb("bars.h40", 2'd3, 2'd0, 2'd3);       // bar 5 at (40,5)
        mode = 2'd2;

        // ---------------------------------------------- frame 3, checkerboard
        go(13234); check_rgb("chk.h32_v0",  2'd3, 2'd3, 2'd3);
        go(15794); check_rgb("chk.h32_v32", 2'd0, 2'd0, 2'd0);
        go(16407); check_rgb("chk.h5_v40",  2'd3, 2'd3, 2'd3);
        mode = 2'd3;

        // -------------------------------------------------- frame 4, white
        go(17665); check_rgb("white.h63", 2'd3, 2'd3, 2'd3);
        go(17666); check_rgb("white.h64_hblank", 2'd0, 2'd0, 2'd0);
        go(21362); check_rgb("white.v47", 2'd3, 2'd3, 2'd3);
        go(21462); check_rgb("white.v48_vblank", 2'd0, 2'd0, 2'd0);

        // ------------------------------------ frame 5, whole-frame counts
        hs_low = 0; vs_low = 0; fs_cnt = 0;
        for (int n = 22000; n < 26400; n++) begin
            go(n);
            if (hsync1 == 1'b0) hs_low++;
            if (vsync1 == 1'b0) vs_low++;
            if (fs1 == 1'b1)    fs_cnt++;
        end
        check("frame.hsync_low", 32'(hs_low), 32'd440);
        check("frame.vsync_low", 32'(vs_low), 32'd160);
        check("frame.fs_count",  32'(fs_cnt), 32'd1);

        // --------------------------- reset mid-frame at (30,20) of frame 6
        go(28030);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst.addr",  32'(addr1),  32'd0);
        check("midrst.hsync", 32'(hsync1), 32'd1);
        check("midrst.vsync", 32'(vsync1), 32'd1);
        check("midrst.fs",    32'(fs1),    32'd0);
        check_rgb("midrst", 2'd0, 2'd0, 2'd0);
        reset = 1'b0;
        cur   = 0;
        check("restart.addr0", 32'(addr1), 32'd0);
        go(1);  check("restart.fs1", 32'(fs1), 32'd0);
        go(2);  check("restart.fs2", 32'(fs1), 32'd1);
        check_rgb("restart.p0", 2'd3, 2'd3, 2'd3);               // mode 3 resampled
        go(3);  check("restart.fs3", 32'(fs1), 32'd0);
        go(83); check("restart.addr_p3_1", 32'(addr1), 32'd1);

        check("addr.max", 32'(max_addr), 32'd767);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/vga_scaled_controller.md
VGA_SCALED_CONTROLLER -- requirements
Module: vga_scaled_controller

Interface
REQ-001 The block SHALL have parameters H_ACTIVE=640, H_FP=16, H_SYNC=96, H_BP=48; V_ACTIVE=480, V_FP=10, V_SYNC=2, V_BP=33.
REQ-002 The block SHALL have parameters COLOR_W=2 (bits per channel, also framebuffer pixel width), SCALE_SHIFT=1 (upscale factor 2^SCALE_SHIFT, legal 0..2), ADDR_W=17, SYNC_POL=0 (0 = active-low syncs).
REQ-003 Port clk, input, 1: pixel clock; the block has exactly one clock.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port mode, input, 2: 0 framebuffer, 1 colour bars, 2 checkerboard, 3 solid white.
REQ-006 Port din, input, COLOR_W: framebuffer read data, valid one clk after addr.
REQ-007 Port addr, output, ADDR_W: framebuffer read address.
REQ-008 Ports hsync and vsync, output, 1 each: VGA syncs with polarity set by SYNC_POL.
REQ-009 Ports R, G, B, output, COLOR_W each: pixel colour.
REQ-010 Port frame_start, output, 1: one-cycle pulse on the first active pixel of each frame, aligned with R/G/B.

Function
REQ-011 h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of H_* parameters) and wrap to 0; v_cnt SHALL advance once per h_cnt wrap, count 0..V_TOTAL-1 and wrap to 0.
REQ-012 Active region SHALL be h_cnt < H_ACTIVE and v_cnt < V_ACTIVE; sync SHALL be asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (vertical analogous).
REQ-013 Framebuffer width FB_W SHALL equal H_ACTIVE >> SCALE_SHIFT; addr SHALL equal (v_cnt>>SCALE_SHIFT)*FB_W + (h_cnt>>SCALE_SHIFT) in the active region.
REQ-014 addr SHALL be generated incrementally with no multiplier: +1 every 2^SCALE_SHIFT active pixels; at line end, rewind to the line-start address unless the next line begins a new framebuffer row, in which case the line start advances by FB_W.
REQ-015 addr SHALL be 0 throughout vertical blanking and hold its last value during horizontal blanking.
REQ-016 Pipeline SHALL be 2 cycles: counters/addr at cycle t, din at t+1, registered R/G/B at t+2; hsync, vsync, active and frame_start SHALL be delayed 2 cycles to match.
REQ-017 When the delayed active flag is low, R/G/B SHALL be 0.
REQ-018 Mode 0 SHALL output R=G=B=din.
REQ-019 Mode 1 SHALL output 8 equal vertical bars across H_ACTIVE; bar index b = h_cnt*8/H_ACTIVE (computed by compare, not divide); R/G/B = all-ones when bit2/bit1/bit0 of b is set, else 0.
REQ-020 Mode 2 SHALL output all-ones when (h_cnt[5] XOR v_cnt[5]) = 1, else 0, on all channels.
REQ-021 Mode 3 SHALL output all-ones on all channels.
REQ-022 mode SHALL be sampled only at h_cnt=0, v_cnt=0; changes mid-frame SHALL take effect from the next frame, so no frame mixes modes.
REQ-023 Test modes SHALL still drive addr per REQ-013..015.

Reset
REQ-024 While reset is high: h_cnt=0, v_cnt=0, addr=0, R=G=B=0, frame_start=0, syncs deasserted, latched mode=0, pipeline flushed.
REQ-025 Reset asserted mid-frame SHALL abort the frame; the first cycle after release SHALL be h_cnt=0, v_cnt=0, and frame_start SHALL pulse 2 cycles after release.

Structure
REQ-026 Default timing constants, mode encodings and a derived-total helper SHALL live in shared package vga_pkg.
REQ-027 The timing counters and raw sync/active generation SHALL be sub-module vga_timing_gen; address generation, pattern generation and the pipeline SHALL stay in the top module.

Verification
REQ-028 Defaults, reset released: hsync low for exactly 96 clk per 800-clk line; vsync low for exactly 2 lines per 525-line frame; frame_start pulses once every 420000 clk.
REQ-029 Mode 0 with din=addr[1:0] model: pixel (h,v)=(3,1) shows colour from addr 1; last active pixel (639,479) reads addr 76799; addr never exceeds 76799.
REQ-030 SCALE_SHIFT=0 with H_ACTIVE=320, V_ACTIVE=240: addr sequence 0..76799 strictly linear across active pixels.
REQ-031 Mode switched 0->1 at v_cnt=100: remainder of frame stays framebuffer; next frame pixel h=80 shows bar 1 (B=2'b11, R=G=0).
REQ-032 Reset pulsed at h=300, v=200: all outputs zero during reset; counters restart at 0; frame_start pulses 2 clk after release.
REQ-033 Any mode: in blanking R=G=B=0; R/G/B transitions align exactly with the 2-cycle-delayed syncs.
